key_event_rx: RTL and testbench
===============================

# key_event_rx

Input-side receiver for the four push keys that feed the game logic. It synchronizes and debounces the raw `key_in` lines and detects press edges. Each press becomes a coded event held in a small FIFO and handed to the consumer over a valid/ready handshake. It replaces direct sampling of raw key levels on a slow scan clock; the consumer sees exactly one event per debounced press.

## Interface
- `DEBOUNCE_CYCLES`, 50000: consecutive cycles a synchronized level must differ from the stable level before it is accepted; legal range 2..65535.
- `DEPTH_LOG2`, 2: FIFO depth is 2**DEPTH_LOG2 entries; legal range 1..4.
- `clk_in` in 1: the single clock; all flops sample on its rising edge.
- `clr` in 1: reset, synchronous and active-high.
- `key_in` in 4: raw key levels, asynchronous, 1 = pressed.
- `evt_ready` in 1: consumer accepts the head event this cycle.
- `evt_valid` out 1: the FIFO is non-empty and the head event is presented.
- `evt_code` out 2: key index of the head event, 0..3.
- `evt_press` out 1: 1 = press, 0 = release. Tied to 1 unless the macro is defined.
- `key_level` out 4: debounced stable key levels.
- `overflow` out 1: sticky flag; an event was dropped.

## Operation
- **Synchronizer:** a 2-flop chain per key produces `sync[3:0]`.
- **Debounce:** one 16-bit counter per key.
  - While `sync[i] == stable[i]`, the counter holds at 0.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1`, on that edge `stable[i] <= sync[i]` and the counter returns to 0.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles returns the counter to 0 and produces no event.
- **Edge detect:**
  - `stable[i]` rising sets `pend_press[i]`.
  - `stable[i]` falling sets `pend_rel[i]`, only when the macro is defined.
- **Arbiter:** each cycle, if any pending flag is set and the FIFO can accept, exactly one event is pushed.
  - Selection is the lowest key index first; for the same key, press is taken before release.
  - The chosen flag clears on the push edge.
- **Overflow:** if an edge arrives for a flag that is already set, the new event is dropped and `overflow` is set to 1. `overflow` stays 1 until `clr`.
- **FIFO:** first-word-fall-through with pointers 1 bit wider than `DEPTH_LOG2`.
  - Full when the pointers differ only in the MSB; empty when they are equal.
  - Pop occurs when `evt_valid && evt_ready`.
  - When full, a push is accepted only in a cycle that also pops.
  - Push and pop in the same cycle keep the count unchanged.
  - Pointers wrap modulo 2*DEPTH.
- **`evt_ready` while `evt_valid` is 0:** ignored; there is no underflow.
- **Event payload:** `{evt_press, evt_code}` is stored per entry. `evt_code` is the binary index of the key.

## Timing
- **Reset values:**
  - Synchronizers, `stable`, counters, pending flags and pointers all clear to 0.
  - `evt_valid`=0, `evt_code`=0, `evt_press`=1, `key_level`=0, `overflow`=0.
- **Reset mid-operation:** `clr` discards FIFO contents and pending events in that cycle. A key still held after reset is released reports as a fresh press after the full latency.
- **Press latency:** `evt_valid` rises DEBOUNCE_CYCLES+4 rising edges after the first edge that samples `key_in[i]` high, with the key held and the FIFO not full. The stages are 2 synchronizer cycles, DEBOUNCE_CYCLES of debounce, 1 pending cycle and 1 FIFO write cycle.
- **`key_level[i]`:** updates DEBOUNCE_CYCLES+2 edges after the level change.
- **Outputs:** all are registered or derived from registered FIFO state; there is no combinational path from `evt_ready` or `key_in` to any output.
- **Throughput:** at most one push and one pop per cycle.
- **Simultaneous presses:** all four keys debounced on the same edge produce events in order 0,1,2,3 on consecutive cycles.

## Configuration
- `KEY_RELEASE_EVENT_EN`
  - **Defined:** falling edges of `stable` set `pend_rel[i]` and push events with `evt_press`=0. FIFO entries are 3 bits wide.
  - **Undefined:** releases only update `key_level`. No release logic or pending-release flags exist, entries are 2 bits wide and `evt_press` is constant 1.

## Test plan
- **Single clean press:** `DEBOUNCE_CYCLES`=8, `evt_ready`=1; hold `key_in`=4'b0100 for 20 cycles.
  - Required: one cycle with `evt_valid`=1 and `evt_code`=2, exactly 12 edges after the first sample.
  - Required: `key_level`=4'b0100.
- **Bounce:** pulse `key_in[0]` high for 5 cycles, low for 2 cycles, then high and held.
  - Required: exactly one event with `evt_code`=0, timed from the final rise.
- **Simultaneous presses:** raise all keys on the same edge with `evt_ready`=1.
  - Required: codes 0,1,2,3 on four consecutive cycles.
- **FIFO full and overflow:** `DEPTH_LOG2`=2, `evt_ready`=0; press keys 0,1,2,3, release all, then press key 0 twice.
  - Required: the FIFO holds 4 events and key 0 press is pending.
  - Required: the second press of key 0 sets `overflow`=1.
  - Required: after `evt_ready`=1, the events drain as 0,1,2,3,0.
- **Reset mid-operation:** assert `clr` for 1 cycle with 3 events queued.
  - Required: next cycle `evt_valid`=0, `overflow`=0, `key_level`=0.
  - Required: a still-held key re-reports after DEBOUNCE_CYCLES+4 edges.
- **`KEY_RELEASE_EVENT_EN` defined:** press then release key 3.
  - Required: events {press=1, code=3} then {press=0, code=3}.

Source files
------------

// File: rtl/key_event_rx.sv
// key_event_rx: four-key receiver. Each raw key is synchronized, debounced and
// edge-detected; presses become coded events in a first-word-fall-through FIFO
// drained over a valid/ready handshake.
// Build macro KEY_RELEASE_EVENT_EN: also report releases (evt_press = 0),
// widening FIFO entries to {press, code}.
module key_event_rx #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DEPTH_LOG2      = 2
) (
  input  logic       clk_in,
  input  logic       clr,
  input  logic [3:0] key_in,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       evt_press,
  output logic [3:0] key_level,
  output logic       overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
`ifdef KEY_RELEASE_EVENT_EN
  localparam int unsigned W = 3;
`else
  localparam int unsigned W = 2;
`endif

  logic [3:0]          sync_q1, key_sync, stable, stable_d;
  logic [15:0]         cnt [4];
  logic [3:0]          press_edge, pend_press, grant_press;
`ifdef KEY_RELEASE_EVENT_EN
  logic [3:0]          rel_edge, pend_rel, grant_rel;
  logic                push_is_press;
`endif
  logic                push, pop, full, can_accept;
  logic [1:0]          push_code;
  logic [W-1:0]        wdata, head;
  logic [W-1:0]        mem [DEPTH];
  logic [DEPTH_LOG2:0] wptr, rptr;

  // Two-flop synchronizer for the asynchronous key lines
  always_ff @(posedge clk_in) begin
    if (clr) begin
      sync_q1  <= '0;
      key_sync <= '0;
    end else begin
      sync_q1  <= key_in;
      key_sync <= sync_q1;
    end
  end

  // Per-key debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing cycles
  always_ff @(posedge clk_in) begin
    if (clr) begin
      stable <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (key_sync[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          cnt[i]    <= '0;
          stable[i] <= key_sync[i];
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  assign press_edge = stable & ~stable_d;
`ifdef KEY_RELEASE_EVENT_EN
  assign rel_edge   = ~stable & stable_d;
`endif

  // Edge capture into pending flags; an edge landing on an already-set flag is dropped and flagged
  always_ff @(posedge clk_in) begin
    if (clr) begin
      stable_d   <= '0;
      pend_press <= '0;
      overflow   <= 1'b0;
`ifdef KEY_RELEASE_EVENT_EN
      pend_rel   <= '0;
`endif
    end else begin
      stable_d   <= stable;
      pend_press <= (pend_press & ~grant_press) | (press_edge & ~pend_press);
`ifdef KEY_RELEASE_EVENT_EN
      pend_rel   <= (pend_rel & ~grant_rel) | (rel_edge & ~pend_rel);
      if (|(press_edge & pend_press) || |(rel_edge & pend_rel)) overflow <= 1'b1;
`else
      if (|(press_edge & pend_press)) overflow <= 1'b1;
`endif
    end
  end

  assign pop        = evt_valid & evt_ready;
  assign full       = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                      (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
  assign can_accept = ~full | pop;

  // Fixed-priority arbiter: lowest key first, press before release of the same key
  always_comb begin
    grant_press   = '0;
    push          = 1'b0;
    push_code     = '0;
`ifdef KEY_RELEASE_EVENT_EN
    grant_rel     = '0;
    push_is_press = 1'b1;
`endif
    if (can_accept) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!push && pend_press[i]) begin
          grant_press[i] = 1'b1;
          push           = 1'b1;
          push_code      = 2'(i);
`ifdef KEY_RELEASE_EVENT_EN
          push_is_press  = 1'b1;
        end else if (!push && pend_rel[i]) begin
          grant_rel[i]   = 1'b1;
          push           = 1'b1;
          push_code      = 2'(i);
          push_is_press  = 1'b0;
`endif
        end
      end
    end
  end

`ifdef KEY_RELEASE_EVENT_EN
  assign wdata = {push_is_press, push_code};
`else
  assign wdata = push_code;
`endif

  // FIFO pointers; one extra MSB separates full from empty
  always_ff @(posedge clk_in) begin
    if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // FIFO storage; contents are meaningless while the pointers say empty
  always_ff @(posedge clk_in) begin
    if (push) mem[wptr[DEPTH_LOG2-1:0]] <= wdata;
  end

  assign head      = mem[rptr[DEPTH_LOG2-1:0]];
  assign evt_valid = (wptr != rptr);
  assign evt_code  = evt_valid ? head[1:0] : 2'b00;
`ifdef KEY_RELEASE_EVENT_EN
  assign evt_press = evt_valid ? head[2] : 1'b1;
`else
  assign evt_press = 1'b1;
`endif
  assign key_level = stable;

endmodule

// File: tb/tb_key_event_rx.sv
// Scoreboard bench for key_event_rx (DEBOUNCE_CYCLES=8, DEPTH_LOG2=2).
// Release expectations are added when KEY_RELEASE_EVENT_EN is defined.
module tb_key_event_rx;

  localparam int D = 8;
  localparam int LAT = D + 4;

  logic       clk_in = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] key_in = '0;
  logic       evt_ready = 1'b1;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_press;
  logic [3:0] key_level;
  logic       overflow;

  key_event_rx #(.DEBOUNCE_CYCLES(D), .DEPTH_LOG2(2)) dut (
    .clk_in(clk_in), .clr(clr), .key_in(key_in), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_press(evt_press),
    .key_level(key_level), .overflow(overflow)
  );

  typedef struct { int press; int code; int cyc; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_evt(input int press, input int code, input int at);
    exp_t e;
    e.press = press; e.code = code; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  // Monitor: every handshake pops the oldest expected event and compares it
  always @(negedge clk_in) begin
    if (!clr && evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: got code %0d press %0d at cycle %0d, expected none",
                 evt_code, evt_press, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("evt_code", int'(evt_code), mon_e.code);
        check("evt_press", int'(evt_press), mon_e.press);
        if (mon_e.cyc >= 0) check("evt_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    // Reset state
    step(3);
    check("rst_valid", int'(evt_valid), 0);
    check("rst_code", int'(evt_code), 0);
    check("rst_press", int'(evt_press), 1);
    check("rst_level", int'(key_level), 0);
    check("rst_overflow", int'(overflow), 0);
    clr = 1'b0;
    step(2);

    // Single clean press of key 2, key_level boundary at D+2 edges
    key_in = 4'b0100;
    expect_evt(1, 2, cyc + LAT);
    step(D + 1);
    check("level_before", int'(key_level), 0);
    step(1);
    check("level_after", int'(key_level), 4);
    step(10);
    key_in = 4'b0000;
`ifdef KEY_RELEASE_EVENT_EN
    expect_evt(0, 2, cyc + LAT);
`endif
    step(20);
    check("level_released", int'(key_level), 0);

    // Bounce on key 0: 5 high, 2 low, then held
    key_in = 4'b0001;
    step(5);
    key_in = 4'b0000;
    step(2);
    key_in = 4'b0001;
    expect_evt(1, 0, cyc + LAT);
    step(25);
    key_in = 4'b0000;
`ifdef KEY_RELEASE_EVENT_EN
    expect_evt(0, 0, cyc + LAT);
`endif
    step(20);

    // Simultaneous presses drain 0..3 on consecutive cycles
    key_in = 4'b1111;
    for (int k = 0; k < 4; k++) expect_evt(1, k, cyc + LAT + k);
    step(20);
    check("level_all", int'(key_level), 15);
    key_in = 4'b0000;
`ifdef KEY_RELEASE_EVENT_EN
    for (int k = 0; k < 4; k++) expect_evt(0, k, cyc + LAT + k);
`endif
    step(20);

    // FIFO full and overflow with the consumer stalled
    evt_ready = 1'b0;
    key_in = 4'b1111;
    for (int k = 0; k < 4; k++) expect_evt(1, k, -1);
    step(20);
    check("full_valid", int'(evt_valid), 1);
    check("full_head", int'(evt_code), 0);
    key_in = 4'b0000;
    step(20);
    check("full_level", int'(key_level), 0);
    key_in = 4'b0001;
    step(20);
    check("ovf_first_press", int'(overflow), 0);
    key_in = 4'b0000;
    step(20);
    key_in = 4'b0001;
    step(20);
    check("ovf_second_press", int'(overflow), 1);
    check("full_head2", int'(evt_code), 0);
    expect_evt(1, 0, -1);
`ifdef KEY_RELEASE_EVENT_EN
    for (int k = 0; k < 4; k++) expect_evt(0, k, -1);
`endif
    evt_ready = 1'b1;
    step(15);
    check("drained_valid", int'(evt_valid), 0);
    check("ovf_sticky", int'(overflow), 1);
    key_in = 4'b0000;
`ifdef KEY_RELEASE_EVENT_EN
    expect_evt(0, 0, cyc + LAT);
`endif
    step(20);

    // Reset mid-operation with 3 events queued and keys still held
    evt_ready = 1'b0;
    key_in = 4'b1110;
    step(20);
    check("queued_valid", int'(evt_valid), 1);
    check("queued_head", int'(evt_code), 1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    evt_ready = 1'b1;
    check("clr_valid", int'(evt_valid), 0);
    check("clr_overflow", int'(overflow), 0);
    check("clr_level", int'(key_level), 0);
    check("clr_press", int'(evt_press), 1);
    for (int k = 1; k < 4; k++) expect_evt(1, k, cyc + LAT + k - 1);
    step(20);
    check("rehold_level", int'(key_level), 14);
    key_in = 4'b0000;
`ifdef KEY_RELEASE_EVENT_EN
    for (int k = 1; k < 4; k++) expect_evt(0, k, cyc + LAT + k - 1);
`endif
    step(20);

    check("sb_empty", sb.size(), 0);
    check("final_valid", int'(evt_valid), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
